// File: rtl/hist_stat_if.sv
// Histogram controller bus bundle.
// Groups the frame/pixel input stream, the dual-port histogram RAM
// (port A read, port B write, both active-low enables) and the readout stream.
// master: environment side (drives pixels and RAM read data).
// slave:  controller side (drives RAM controls and readout).
interface hist_stat_if;
  logic        frame_start;
  logic        frame_end;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [7:0]  ram_aa;
  logic        ram_cena;
  logic [13:0] ram_qa;
  logic [7:0]  ram_ab;
  logic        ram_cenb;
  logic [13:0] ram_db;
  logic        hist_valid;
  logic [7:0]  hist_bin;
  logic [13:0] hist_count;
  logic        hist_done;
  logic        busy;
  logic        frm_err;

  modport master (
    output frame_start, frame_end, pix_valid, pix_data, ram_qa,
    input  ram_aa, ram_cena, ram_ab, ram_cenb, ram_db,
    input  hist_valid, hist_bin, hist_count, hist_done, busy, frm_err
  );

  modport slave (
    input  frame_start, frame_end, pix_valid, pix_data, ram_qa,
    output ram_aa, ram_cena, ram_ab, ram_cenb, ram_db,
    output hist_valid, hist_bin, hist_count, hist_done, busy, frm_err
  );
endinterface

// File: rtl/hist_stat_ctrl.sv
// 256-bin, 14-bit histogram controller over an external dual-port RAM.
// Ports:
//   clk  - sole clock, rising edge.
//   rst  - asynchronous active-high reset; restarts the 256-cycle bin clear.
//   bus  - hist_stat_if.slave: frame/pixel stream in, RAM port A read
//          (ram_qa registered, one cycle after ram_cena=0), RAM port B write,
//          readout stream (hist_valid/hist_bin/hist_count, hist_done), busy, frm_err.
// Parameter SAT_EN: 1 = counts saturate at 16383, 0 = counts wrap modulo 2^14.
module hist_stat_ctrl #(
  parameter bit SAT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  hist_stat_if.slave bus
);

  typedef enum logic [2:0] {StClear, StIdle, StAccum, StDrain, StReadout} state_e;

  localparam logic [13:0] CntMax = 14'h3FFF;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  // Read-modify-write pipeline: stage 1 holds the bin read last cycle.
  logic        p1_vld_q, p1_vld_d;
  logic [7:0]  p1_bin_q, p1_bin_d;
  // Last accumulation write, forwarded when the next increment hits the same bin.
  logic        wr_vld_q, wr_vld_d;
  logic [7:0]  wr_bin_q, wr_bin_d;
  logic [13:0] wr_data_q, wr_data_d;
  // Readout values held while hist_valid is low.
  logic [7:0]  hold_bin_q, hold_bin_d;
  logic [13:0] hold_cnt_q, hold_cnt_d;

  logic [13:0] base, incr;
  logic [7:0]  rd_bin;

  logic        ram_cena, ram_cenb, hist_valid, hist_done, busy, frm_err;
  logic [7:0]  ram_aa, ram_ab, hist_bin;
  logic [13:0] ram_db, hist_count;

  // The RAM has not yet seen last cycle's write when it is read back-to-back.
  assign base   = (wr_vld_q && (wr_bin_q == p1_bin_q)) ? wr_data_q : bus.ram_qa;
  assign incr   = (base == CntMax) ? (SAT_EN ? CntMax : 14'd0) : base + 14'd1;
  // Readout beat at count k+1 reports bin k; count 256 wraps to bin 255.
  assign rd_bin = cnt_q[7:0] - 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p1_vld_d   = 1'b0;
    p1_bin_d   = p1_bin_q;
    wr_vld_d   = 1'b0;
    wr_bin_d   = wr_bin_q;
    wr_data_d  = wr_data_q;
    hold_bin_d = hold_bin_q;
    hold_cnt_d = hold_cnt_q;
    ram_aa     = 8'd0;
    ram_cena   = 1'b1;
    ram_ab     = 8'd0;
    ram_cenb   = 1'b1;
    ram_db     = 14'd0;
    hist_valid = 1'b0;
    hist_bin   = hold_bin_q;
    hist_count = hold_cnt_q;
    hist_done  = 1'b0;
    busy       = (state_q != StIdle);
    frm_err    = 1'b0;

    // Write stage runs regardless of state so the last frame pixel lands in DRAIN.
    if (p1_vld_q) begin
      ram_ab    = p1_bin_q;
      ram_cenb  = 1'b0;
      ram_db    = incr;
      wr_vld_d  = 1'b1;
      wr_bin_d  = p1_bin_q;
      wr_data_d = incr;
    end

    unique case (state_q)
      StClear: begin
        ram_ab   = cnt_q[7:0];
        ram_cenb = 1'b0;
        ram_db   = 14'd0;
        if (bus.frame_start || bus.pix_valid) frm_err = 1'b1;
        if (cnt_q == 9'd255) begin
          state_d = StIdle;
          cnt_d   = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StIdle: begin
        if (bus.pix_valid) frm_err = 1'b1;
        if (bus.frame_start) state_d = StAccum;
      end
      StAccum: begin
        if (bus.frame_start) frm_err = 1'b1;
        if (bus.pix_valid) begin
          ram_aa   = bus.pix_data;
          ram_cena = 1'b0;
          p1_vld_d = 1'b1;
          p1_bin_d = bus.pix_data;
        end
        if (bus.frame_end) begin
          state_d = StDrain;
          cnt_d   = 9'd0;
        end
      end
      StDrain: begin
        if (bus.frame_start || bus.pix_valid) frm_err = 1'b1;
        if (cnt_q == 9'd1) begin
          state_d = StReadout;
          cnt_d   = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StReadout: begin
        if (bus.frame_start || bus.pix_valid) frm_err = 1'b1;
        if (cnt_q <= 9'd255) begin
          ram_aa   = cnt_q[7:0];
          ram_cena = 1'b0;
        end
        // Report the bin read last cycle and zero it for the next frame.
        if ((cnt_q != 9'd0) && (cnt_q <= 9'd256)) begin
          hist_valid = 1'b1;
          hist_bin   = rd_bin;
          hist_count = bus.ram_qa;
          hold_bin_d = rd_bin;
          hold_cnt_d = bus.ram_qa;
          ram_ab     = rd_bin;
          ram_cenb   = 1'b0;
          ram_db     = 14'd0;
        end
        if (cnt_q == 9'd257) begin
          hist_done = 1'b1;
          state_d   = StIdle;
          cnt_d     = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = 9'd0;
      end
    endcase

    // State already sits at CLEAR bin 0 during reset; keep the RAM untouched.
    if (rst) begin
      ram_aa     = 8'd0;
      ram_cena   = 1'b1;
      ram_ab     = 8'd0;
      ram_cenb   = 1'b1;
      ram_db     = 14'd0;
      hist_valid = 1'b0;
      hist_bin   = 8'd0;
      hist_count = 14'd0;
      hist_done  = 1'b0;
      busy       = 1'b1;
      frm_err    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      cnt_q      <= 9'd0;
      p1_vld_q   <= 1'b0;
      p1_bin_q   <= 8'd0;
      wr_vld_q   <= 1'b0;
      wr_bin_q   <= 8'd0;
      wr_data_q  <= 14'd0;
      hold_bin_q <= 8'd0;
      hold_cnt_q <= 14'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p1_vld_q   <= p1_vld_d;
      p1_bin_q   <= p1_bin_d;
      wr_vld_q   <= wr_vld_d;
      wr_bin_q   <= wr_bin_d;
      wr_data_q  <= wr_data_d;
      hold_bin_q <= hold_bin_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.ram_aa     = ram_aa;
  assign bus.ram_cena   = ram_cena;
  assign bus.ram_ab     = ram_ab;
  assign bus.ram_cenb   = ram_cenb;
  assign bus.ram_db     = ram_db;
  assign bus.hist_valid = hist_valid;
  assign bus.hist_bin   = hist_bin;
  assign bus.hist_count = hist_count;
  assign bus.hist_done  = hist_done;
  assign bus.busy       = busy;
  assign bus.frm_err    = frm_err;

endmodule

// File: tb/tb_hist_stat_ctrl.sv
// Bench for hist_stat_ctrl: two instances (SAT_EN=1 and SAT_EN=0) share one
// stimulus stream, each with its own behavioural RAM (registered read data).
module tb_hist_stat_ctrl;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hist_stat_if if0 ();
  hist_stat_if if1 ();

  hist_stat_ctrl #(.SAT_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  hist_stat_ctrl #(.SAT_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  assign if1.frame_start = if0.frame_start;
  assign if1.frame_end   = if0.frame_end;
  assign if1.pix_valid   = if0.pix_valid;
  assign if1.pix_data    = if0.pix_data;

  logic [13:0] mem0 [256];
  logic [13:0] mem1 [256];

  always @(posedge clk) begin
    if (if0.ram_cena === 1'b0) if0.ram_qa <= mem0[if0.ram_aa];
    if (if0.ram_cenb === 1'b0) mem0[if0.ram_ab] <= if0.ram_db;
    if (if1.ram_cena === 1'b0) if1.ram_qa <= mem1[if1.ram_aa];
    if (if1.ram_cenb === 1'b0) mem1[if1.ram_ab] <= if1.ram_db;
  end

  // Readout capture: latest count per bin, beat/done/error totals, bin order.
  logic [13:0] hist_v [2][256];
  int beats [2] = '{0, 0};
  int dones [2] = '{0, 0};
  int errs  [2] = '{0, 0};
  int order_err [2] = '{0, 0};

  always @(negedge clk) begin
    if (if0.hist_valid === 1'b1) begin
      hist_v[0][if0.hist_bin] = if0.hist_count;
      if (int'(if0.hist_bin) !== beats[0] % 256) order_err[0]++;
      beats[0]++;
    end
    if (if0.hist_done === 1'b1) dones[0]++;
    if (if0.frm_err === 1'b1) errs[0]++;
    if (if1.hist_valid === 1'b1) begin
      hist_v[1][if1.hist_bin] = if1.hist_count;
      if (int'(if1.hist_bin) !== beats[1] % 256) order_err[1]++;
      beats[1]++;
    end
    if (if1.hist_done === 1'b1) dones[1]++;
    if (if1.frm_err === 1'b1) errs[1]++;
  end

  int checks = 0;
  int failures = 0;
  int sb [2];
  int sd [2];
  int se [2];
  int so [2];

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      sb[d] = beats[d];
      sd[d] = dones[d];
      se[d] = errs[d];
      so[d] = order_err[d];
    end
  endtask

  function automatic int count_diff(input int d, input logic [13:0] e [256]);
    int n = 0;
    for (int b = 0; b < 256; b++) if (hist_v[d][b] !== e[b]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    if0.frame_start = 1'b1;
    tick();
    if0.frame_start = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] v);
    if0.pix_valid = 1'b1;
    if0.pix_data  = v;
    tick();
    if0.pix_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit to);
    lat = -1;
    to  = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (lat < 0 && if0.hist_valid === 1'b1) lat = n;
      if (if0.hist_done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    tick();
  endtask

  task automatic end_frame(input bit pv, input logic [7:0] v, output int lat, output bit to);
    if0.frame_end = 1'b1;
    if0.pix_valid = pv;
    if0.pix_data  = v;
    tick();
    if0.frame_end = 1'b0;
    if0.pix_valid = 1'b0;
    wait_done(lat, to);
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if0.ram_cena, if0.ram_cenb, if0.busy, if0.hist_valid, if0.hist_done, if0.frm_err,
         if1.ram_cena, if1.ram_cenb, if1.busy, if1.hist_valid, if1.hist_done, if1.frm_err}
        !== 12'b111000_111000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b %b, required 111000 111000",
               {if0.ram_cena, if0.ram_cenb, if0.busy, if0.hist_valid, if0.hist_done, if0.frm_err},
               {if1.ram_cena, if1.ram_cenb, if1.busy, if1.hist_valid, if1.hist_done, if1.frm_err});
    end
    checks++;
    if ({if0.ram_aa, if0.ram_ab, if0.ram_db, if0.hist_bin, if0.hist_count,
         if1.ram_aa, if1.ram_ab, if1.ram_db, if1.hist_bin, if1.hist_count} !== '0) begin
      failures++;
      $display("FAIL reset_data: aa=%0d ab=%0d db=%0d bin=%0d cnt=%0d, required all 0",
               if0.ram_aa, if0.ram_ab, if0.ram_db, if0.hist_bin, if0.hist_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (if0.ram_cenb !== 1'b0 || if0.ram_ab !== 8'(i) || if0.ram_db !== 14'd0 ||
          if0.busy !== 1'b1 || if0.hist_valid !== 1'b0) bad++;
      if (if1.ram_cenb !== 1'b0 || if1.ram_ab !== 8'(i) || if1.ram_db !== 14'd0 ||
          if1.busy !== 1'b1 || if1.hist_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clear_sweep: %0d bad clear cycles, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({if0.busy, if1.busy} !== 2'b00) begin
      failures++;
      $display("FAIL clear_end_busy: got %b, required 00", {if0.busy, if1.busy});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit to;
    logic [13:0] e [256];
    snap();
    start_frame();
    repeat (10) pixel(8'd7);
    end_frame(1'b0, 8'd0, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== 4) begin
      failures++;
      $display("FAIL b2b_timing: timeout=%0d first_beat=%0d, required 0 and 4", to, lat);
    end
    for (int b = 0; b < 256; b++) e[b] = 14'd0;
    e[7] = 14'd10;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ((beats[d] - sb[d]) !== 256 || (dones[d] - sd[d]) !== 1 ||
          (order_err[d] - so[d]) !== 0 || (errs[d] - se[d]) !== 0) begin
        failures++;
        $display("FAIL b2b_readout dut%0d: beats=%0d dones=%0d order=%0d errs=%0d, required 256/1/0/0",
                 d, beats[d] - sb[d], dones[d] - sd[d], order_err[d] - so[d], errs[d] - se[d]);
      end
      checks++;
      if (count_diff(d, e) !== 0 || hist_v[d][7] !== 14'd10) begin
        failures++;
        $display("FAIL b2b_bins dut%0d: bin7=%0d bad_bins=%0d, required 10 and 0",
                 d, hist_v[d][7], count_diff(d, e));
      end
    end
    @(negedge clk);
    checks++;
    if ({if0.hist_valid, if0.hist_bin, if0.hist_count, if0.busy} !== {1'b0, 8'd255, 14'd0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_hold: valid=%0d bin=%0d cnt=%0d busy=%0d, required 0 255 0 0",
               if0.hist_valid, if0.hist_bin, if0.hist_count, if0.busy);
    end
    tick();
  endtask

  task automatic test_frame_end_pixel();
    int lat;
    bit to;
    logic [13:0] e [256];
    snap();
    start_frame();
    pixel(8'd3);
    pixel(8'd5);
    pixel(8'd3);
    pixel(8'd3);
    end_frame(1'b1, 8'd5, lat, to);
    for (int b = 0; b < 256; b++) e[b] = 14'd0;
    e[3] = 14'd3;
    e[5] = 14'd2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (to !== 1'b0 || (beats[d] - sb[d]) !== 256 || (dones[d] - sd[d]) !== 1 ||
          (errs[d] - se[d]) !== 0) begin
        failures++;
        $display("FAIL fe_readout dut%0d: timeout=%0d beats=%0d dones=%0d errs=%0d, required 0/256/1/0",
                 d, to, beats[d] - sb[d], dones[d] - sd[d], errs[d] - se[d]);
      end
      checks++;
      if (count_diff(d, e) !== 0) begin
        failures++;
        $display("FAIL fe_bins dut%0d: bin3=%0d bin5=%0d bad_bins=%0d, required 3 2 0",
                 d, hist_v[d][3], hist_v[d][5], count_diff(d, e));
      end
    end
  endtask

  task automatic test_start_in_readout();
    int lat;
    bit to;
    int seen = 0;
    logic [13:0] e [256];
    snap();
    start_frame();
    pixel(8'd9);
    pixel(8'd9);
    if0.frame_end = 1'b1;
    tick();
    if0.frame_end = 1'b0;
    for (int n = 0; n < 300 && seen < 20; n++) begin
      @(negedge clk);
      if (if0.hist_valid === 1'b1) seen++;
    end
    tick();
    if0.frame_start = 1'b1;
    @(negedge clk);
    checks++;
    if ({if0.frm_err, if1.frm_err, if0.busy} !== 3'b111) begin
      failures++;
      $display("FAIL rdo_start_err: frm_err=%b busy=%0d, required 11 and 1",
               {if0.frm_err, if1.frm_err}, if0.busy);
    end
    tick();
    if0.frame_start = 1'b0;
    wait_done(lat, to);
    for (int b = 0; b < 256; b++) e[b] = 14'd0;
    e[9] = 14'd2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (to !== 1'b0 || (beats[d] - sb[d]) !== 256 || (dones[d] - sd[d]) !== 1 ||
          (errs[d] - se[d]) !== 1) begin
        failures++;
        $display("FAIL rdo_readout dut%0d: timeout=%0d beats=%0d dones=%0d errs=%0d, required 0/256/1/1",
                 d, to, beats[d] - sb[d], dones[d] - sd[d], errs[d] - se[d]);
      end
      checks++;
      if (count_diff(d, e) !== 0) begin
        failures++;
        $display("FAIL rdo_bins dut%0d: bin9=%0d bad_bins=%0d, required 2 and 0",
                 d, hist_v[d][9], count_diff(d, e));
      end
    end
    @(negedge clk);
    checks++;
    if ({if0.busy, if1.busy} !== 2'b00) begin
      failures++;
      $display("FAIL rdo_idle: busy=%b, required 00", {if0.busy, if1.busy});
    end
    tick();
  endtask

  task automatic test_second_frame();
    int lat;
    bit to;
    logic [13:0] e [256];
    snap();
    start_frame();
    end_frame(1'b1, 8'd0, lat, to);
    for (int b = 0; b < 256; b++) e[b] = 14'd0;
    e[0] = 14'd1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (to !== 1'b0 || count_diff(d, e) !== 0 || (beats[d] - sb[d]) !== 256) begin
        failures++;
        $display("FAIL second_bins dut%0d: timeout=%0d bin0=%0d bin9=%0d bad_bins=%0d, required 0 1 0 0",
                 d, to, hist_v[d][0], hist_v[d][9], count_diff(d, e));
      end
    end
  endtask

  task automatic test_drop_errors();
    int lat;
    bit to;
    logic [13:0] e [256];
    snap();
    if0.pix_valid = 1'b1;
    if0.pix_data  = 8'd77;
    @(negedge clk);
    checks++;
    if ({if0.ram_cena, if0.ram_cenb, if1.ram_cena, if1.ram_cenb, if0.frm_err, if1.frm_err}
        !== 6'b111111) begin
      failures++;
      $display("FAIL idle_pix_drop: cena/cenb/err=%b, required 111111",
               {if0.ram_cena, if0.ram_cenb, if1.ram_cena, if1.ram_cenb, if0.frm_err, if1.frm_err});
    end
    tick();
    if0.pix_valid = 1'b0;
    if0.frame_end = 1'b1;
    @(negedge clk);
    checks++;
    if ({if0.frm_err, if1.frm_err, if0.busy, if1.busy} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_frame_end: err/busy=%b, required 0000",
               {if0.frm_err, if1.frm_err, if0.busy, if1.busy});
    end
    tick();
    if0.frame_end = 1'b0;
    start_frame();
    pixel(8'd20);
    if0.frame_end = 1'b1;
    tick();
    if0.frame_end = 1'b0;
    if0.pix_valid = 1'b1;
    if0.pix_data  = 8'd21;
    @(negedge clk);
    checks++;
    if ({if0.ram_cena, if1.ram_cena, if0.frm_err, if1.frm_err} !== 4'b1111) begin
      failures++;
      $display("FAIL drain_pix_drop: cena/err=%b, required 1111",
               {if0.ram_cena, if1.ram_cena, if0.frm_err, if1.frm_err});
    end
    tick();
    if0.pix_valid = 1'b0;
    wait_done(lat, to);
    for (int b = 0; b < 256; b++) e[b] = 14'd0;
    e[20] = 14'd1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (to !== 1'b0 || count_diff(d, e) !== 0 || (errs[d] - se[d]) !== 2) begin
        failures++;
        $display("FAIL drop_bins dut%0d: timeout=%0d bin20=%0d bin21=%0d errs=%0d, required 0 1 0 2",
                 d, to, hist_v[d][20], hist_v[d][21], errs[d] - se[d]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    bit to;
    logic [13:0] e [256];
    snap();
    start_frame();
    repeat (16390) pixel(8'd255);
    end_frame(1'b0, 8'd0, lat, to);
    for (int b = 0; b < 256; b++) e[b] = 14'd0;
    for (int d = 0; d < 2; d++) begin
      e[255] = (d == 0) ? 14'd16383 : 14'd6;
      checks++;
      if (to !== 1'b0 || count_diff(d, e) !== 0) begin
        failures++;
        $display("FAIL sat_bins dut%0d: timeout=%0d bin255=%0d bad_bins=%0d, required 0 %0d 0",
                 d, to, hist_v[d][255], count_diff(d, e), e[255]);
      end
    end
    @(negedge clk);
    checks++;
    if ({if0.hist_bin, if0.hist_count, if1.hist_bin, if1.hist_count} !==
        {8'd255, 14'd16383, 8'd255, 14'd6}) begin
      failures++;
      $display("FAIL sat_hold: %0d/%0d and %0d/%0d, required 255/16383 and 255/6",
               if0.hist_bin, if0.hist_count, if1.hist_bin, if1.hist_count);
    end
    tick();
  endtask

  task automatic test_reset_mid_accum();
    int lat;
    bit to;
    int n = 0;
    logic [13:0] e [256];
    start_frame();
    repeat (5) pixel(8'd42);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({if0.busy, if1.busy, if0.ram_cena, if1.ram_cena, if0.ram_cenb, if1.ram_cenb} !== 6'b111111) begin
      failures++;
      $display("FAIL midrst_outputs: busy/cena/cenb=%b, required 111111",
               {if0.busy, if1.busy, if0.ram_cena, if1.ram_cena, if0.ram_cenb, if1.ram_cenb});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (if0.busy !== 1'b1) break;
      n++;
    end
    checks++;
    if (n !== 256 || if1.busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear_len: busy cycles=%0d dut1_busy=%0d, required 256 and 0", n, if1.busy);
    end
    tick();
    snap();
    start_frame();
    pixel(8'd42);
    pixel(8'd100);
    end_frame(1'b0, 8'd0, lat, to);
    for (int b = 0; b < 256; b++) e[b] = 14'd0;
    e[42]  = 14'd1;
    e[100] = 14'd1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (to !== 1'b0 || count_diff(d, e) !== 0 || (dones[d] - sd[d]) !== 1) begin
        failures++;
        $display("FAIL midrst_bins dut%0d: timeout=%0d bin42=%0d bin100=%0d bad_bins=%0d, required 0 1 1 0",
                 d, to, hist_v[d][42], hist_v[d][100], count_diff(d, e));
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    if0.frame_start = 1'b0;
    if0.frame_end   = 1'b0;
    if0.pix_valid   = 1'b0;
    if0.pix_data    = 8'd0;
    test_reset();
    test_back_to_back();
    test_frame_end_pixel();
    test_start_in_readout();
    test_second_frame();
    test_drop_errors();
    test_saturation();
    test_reset_mid_accum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hist_stat_ctrl.md
HIST_STAT_CTRL -- requirements
Module: hist_stat_ctrl

Interface
REQ-001 Parameter SAT_EN, default 1: 1 = bin counts saturate at 16383; 0 = counts wrap modulo 2^14.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 frame_start  in  1  one-cycle pulse that opens a frame.
REQ-005 frame_end  in  1  one-cycle pulse that closes a frame.
REQ-006 pix_valid  in  1  pixel qualifier.
REQ-007 pix_data  in  8  pixel grey level, which is the bin index.
REQ-008 ram_aa  out  8  RAM read address.
REQ-009 ram_cena  out  1  RAM read enable, active-low.
REQ-010 ram_qa  in  14  RAM read data, registered, valid one cycle after ram_cena=0.
REQ-011 ram_ab  out  8  RAM write address.
REQ-012 ram_cenb  out  1  RAM write enable, active-low.
REQ-013 ram_db  out  14  RAM write data.
REQ-014 hist_valid  out  1  histogram readout qualifier.
REQ-015 hist_bin  out  8  readout bin index.
REQ-016 hist_count  out  14  readout bin count.
REQ-017 hist_done  out  1  one-cycle pulse after the last readout beat.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frm_err  out  1  one-cycle pulse when frame_start is ignored or a pixel is dropped.

Function
REQ-020 States: CLEAR, IDLE, ACCUM, DRAIN, READOUT.
REQ-021 CLEAR: write 0 to bins 0..255, one bin per cycle, in ascending order (256 cycles); then go to IDLE.
REQ-022 IDLE: on frame_start, go to ACCUM on the next cycle.
REQ-023 ACCUM: in cycle t with pix_valid=1, drive ram_aa=pix_data and ram_cena=0.
REQ-024 ACCUM, cycle t+1: drive ram_ab=that bin, ram_cenb=0, ram_db=base+1.
REQ-025 base is ram_qa, except when the previous cycle wrote the same bin; then base is the data of that previous write (one-deep forward).
REQ-026 Back-to-back identical pixels at full rate SHALL count exactly, with no lost increments.
REQ-027 Saturation: with SAT_EN=1, base=16383 writes 16383; with SAT_EN=0, it writes 0.
REQ-028 ACCUM: on frame_end, go to DRAIN; a pixel with pix_valid=1 in the frame_end cycle is counted.
REQ-029 DRAIN: lasts 2 cycles so that every pending write completes; then go to READOUT.
REQ-030 READOUT, cycle k (k=0..255): ram_aa=k, ram_cena=0.
REQ-031 READOUT, cycle k+1: hist_valid=1, hist_bin=k, hist_count=ram_qa; the same cycle writes 0 to bin k (ram_ab=k, ram_db=0, ram_cenb=0).
REQ-032 READOUT ends with hist_done pulsed in the cycle after the beat for bin 255; then go to IDLE.
REQ-033 Readout SHALL leave every bin at 0, so no separate CLEAR is needed between frames.
REQ-034 pix_valid outside ACCUM, or outside the frame_end cycle, SHALL be dropped with a frm_err pulse and no RAM access.
REQ-035 frame_start in CLEAR, ACCUM, DRAIN or READOUT SHALL be ignored with a frm_err pulse.
REQ-036 frame_end outside ACCUM SHALL be ignored silently.
REQ-037 ram_cena and ram_cenb SHALL be 1 in every cycle with no access.
REQ-038 hist_bin and hist_count SHALL hold their last values when hist_valid=0.

Reset
REQ-039 RST=1 forces state CLEAR at bin 0 and clears the pipeline and forward registers.
REQ-040 During RST=1: ram_cena=1, ram_cenb=1, hist_valid=0, hist_done=0, frm_err=0, busy=1, and all address/data outputs 0.
REQ-041 Reset asserted mid-ACCUM or mid-READOUT SHALL abandon the frame; the full 256-cycle CLEAR runs after release.

Verification
REQ-042 Scenario: release reset -> 256 writes of 0 to bins 0..255, busy falls after 256 cycles, no hist_valid.
REQ-043 Scenario: frame of 10 back-to-back pixels of value 7 -> readout bin 7 = 10, every other bin = 0.
REQ-044 Scenario: pixels 3,5,3,3,5 consecutive, last pixel in the frame_end cycle -> bin 3 = 3, bin 5 = 2.
REQ-045 Scenario: SAT_EN=1, 16390 pixels of value 255 -> bin 255 = 16383; repeat with SAT_EN=0 -> bin 255 = 6.
REQ-046 Scenario: frame_start during READOUT -> frm_err pulse, readout completes with hist_done.
REQ-047 Scenario: a second frame with one pixel of 0 -> readout bin 0 = 1, with no carry-over from the first frame.
REQ-048 Scenario: reset pulsed mid-ACCUM -> CLEAR reruns, and the next frame's counts exclude the pre-reset pixels.
